// File: rtl/cam_cov_if.sv
// Snoop bundle between the CAM environment and the coverage monitor.
// The master drives the request and DUT-response pins; the slave (monitor) returns the cover and error outputs.
interface cam_cov_if #(
  parameter int camsize_p   = 8,
  parameter int key_width_p = 16,
  parameter int val_width_p = 32
);
  logic                   valid_i;
  logic                   rw_n_i;
  logic [key_width_p-1:0] key_i;
  logic [val_width_p-1:0] val_i;
  logic                   dut_valid_i;
  logic [val_width_p-1:0] dut_val_i;
  logic [camsize_p-1:0]   evict_cov_o;
  logic [camsize_p-1:0]   hit_cov_o;
  logic                   ww_cov_o;
  logic                   wr_cov_o;
  logic                   read_error_o;
  logic [15:0]            err_cnt_o;

  modport master (
    output valid_i, rw_n_i, key_i, val_i, dut_valid_i, dut_val_i,
    input  evict_cov_o, hit_cov_o, ww_cov_o, wr_cov_o, read_error_o, err_cnt_o
  );

  modport slave (
    input  valid_i, rw_n_i, key_i, val_i, dut_valid_i, dut_val_i,
    output evict_cov_o, hit_cov_o, ww_cov_o, wr_cov_o, read_error_o, err_cnt_o
  );
endinterface

// File: rtl/cam_cov_monitor.sv
// True-LRU shadow of the CAM under test: checks read responses one cycle after
// each read hit and collects sticky hit/evict/back-to-back cover bits.
module cam_cov_monitor #(
  parameter int camsize_p   = 8,
  parameter int key_width_p = 16,
  parameter int val_width_p = 32
) (
  input logic     clk,
  input logic     rst_n,
  cam_cov_if.slave bus
);
  localparam int AW = (camsize_p > 1) ? $clog2(camsize_p) : 1;
  localparam logic [AW-1:0] LRU_AGE = AW'(camsize_p - 1);

  logic [camsize_p-1:0]   ent_vld;
  logic [key_width_p-1:0] ent_key [camsize_p];
  logic [val_width_p-1:0] ent_val [camsize_p];
  logic [AW-1:0]          ent_age [camsize_p];

  logic                   hit;
  logic [AW-1:0]          hit_idx;
  logic                   free_found;
  logic [AW-1:0]          free_idx;
  logic [AW-1:0]          lru_idx;
  logic                   wr_op;
  logic                   rd_hit;
  logic                   touch;
  logic                   evict;
  logic [AW-1:0]          touch_idx;
  logic [AW-1:0]          touch_age;
  logic                   read_err;

  logic                   vld_p1;
  logic [val_width_p-1:0] exp_val_p1;
  logic                   prev_vld_p1;
  logic                   prev_rw_n_p1;
  logic [key_width_p-1:0] prev_key_p1;

  logic [camsize_p-1:0]   evict_cov;
  logic [camsize_p-1:0]   hit_cov;
  logic                   ww_cov;
  logic                   wr_cov;
  logic                   read_error;
  logic [15:0]            err_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    lru_idx    = '0;
    for (int i = 0; i < camsize_p; i++) begin
      if (ent_vld[i] && ent_key[i] == bus.key_i) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
      if (ent_age[i] == LRU_AGE) lru_idx = AW'(i);
    end
    // Scan downward so the lowest-index free slot wins
    for (int i = camsize_p - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  assign wr_op     = bus.valid_i && !bus.rw_n_i;
  assign rd_hit    = bus.valid_i && bus.rw_n_i && hit;
  assign touch     = wr_op || rd_hit;
  assign evict     = wr_op && !hit && !free_found;
  assign touch_idx = hit ? hit_idx : (free_found ? free_idx : lru_idx);
  // An invalid slot being filled behaves as if it were the LRU entry
  assign touch_age = ent_vld[touch_idx] ? ent_age[touch_idx] : LRU_AGE;

  assign read_err  = vld_p1 ? (!bus.dut_valid_i || bus.dut_val_i != exp_val_p1)
                            : bus.dut_valid_i;

  // Stage p0 -> shadow state update (LRU bookkeeping)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < camsize_p; i++) ent_age[i] <= '0;
    end else if (touch) begin
      for (int i = 0; i < camsize_p; i++) begin
        if (ent_vld[i] && ent_age[i] < touch_age) ent_age[i] <= ent_age[i] + 1'b1;
      end
      ent_age[touch_idx] <= '0;
      ent_vld[touch_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_op) begin
      ent_key[touch_idx] <= bus.key_i;
      ent_val[touch_idx] <= bus.val_i;
    end
    if (rd_hit) exp_val_p1 <= ent_val[hit_idx];
    prev_key_p1 <= bus.key_i;
  end

  // Stage p1 -> response check and cover collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      prev_vld_p1  <= 1'b0;
      prev_rw_n_p1 <= 1'b0;
      evict_cov    <= '0;
      hit_cov      <= '0;
      ww_cov       <= 1'b0;
      wr_cov       <= 1'b0;
      read_error   <= 1'b0;
      err_cnt      <= '0;
    end else begin
      vld_p1       <= rd_hit;
      prev_vld_p1  <= bus.valid_i;
      prev_rw_n_p1 <= bus.rw_n_i;
      read_error   <= read_err;
      if (read_err) err_cnt <= sat_inc(err_cnt);
      if (bus.valid_i && hit) hit_cov[hit_idx] <= 1'b1;
      if (evict) evict_cov[lru_idx] <= 1'b1;
      if (bus.valid_i && prev_vld_p1 && !prev_rw_n_p1 && bus.key_i == prev_key_p1) begin
        if (bus.rw_n_i) wr_cov <= 1'b1;
        else            ww_cov <= 1'b1;
      end
    end
  end

  assign bus.evict_cov_o  = evict_cov;
  assign bus.hit_cov_o    = hit_cov;
  assign bus.ww_cov_o     = ww_cov;
  assign bus.wr_cov_o     = wr_cov;
  assign bus.read_error_o = read_error;
  assign bus.err_cnt_o    = err_cnt;
endmodule
